// File: rtl/player_fsm_if.sv
// ============================================================================
// Module : player_fsm_if
// Brief  : Player action/opponent inputs and registered player status outputs.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface player_fsm_if;
  logic [2:0] action;
  logic [3:0] opp_pos;
  logic [3:0] pos;
  logic [2:0] state;
  logic       hit;
  logic [1:0] hit_dmg;
  logic       airborne;
  logic       guarding;
  logic       busy;

  modport master (
    output action, opp_pos,
    input  pos, state, hit, hit_dmg, airborne, guarding, busy
  );

  modport slave (
    input  action, opp_pos,
    output pos, state, hit, hit_dmg, airborne, guarding, busy
  );
endinterface

`default_nettype wire

// File: rtl/player_fsm.sv
// ============================================================================
// Module : player_fsm
// Brief  : Fighting-game player controller: move, jump, kick, punch, guard.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module player_fsm #(
  parameter logic [3:0] START_POS    = 4'd2,
  parameter logic [3:0] MAX_POS      = 4'd15,
  parameter int         JUMP_CYCLES  = 4,
  parameter int         KICK_CYCLES  = 3,
  parameter int         PUNCH_CYCLES = 2,
  parameter int         KICK_RANGE   = 2,
  parameter int         PUNCH_RANGE  = 1
) (
  input  wire logic      clk,
  input  wire logic      rst,
  player_fsm_if.slave    bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_JUMP  = 3'd1,
    ST_KICK  = 3'd2,
    ST_PUNCH = 3'd3,
    ST_GUARD = 3'd4
  } state_t;

  localparam logic [2:0] C_ACT_NONE  = 3'd0;
  localparam logic [2:0] C_ACT_JUMP  = 3'd1;
  localparam logic [2:0] C_ACT_KICK  = 3'd2;
  localparam logic [2:0] C_ACT_PUNCH = 3'd3;
  localparam logic [2:0] C_ACT_GUARD = 3'd4;
  localparam logic [2:0] C_ACT_FWD   = 3'd5;
  localparam logic [2:0] C_ACT_BACK  = 3'd6;
  localparam logic [2:0] C_ACT_RSVD  = 3'd7;

  localparam logic [3:0] C_JUMP_LAST  = 4'(JUMP_CYCLES - 1);
  localparam logic [3:0] C_KICK_LAST  = 4'(KICK_CYCLES - 1);
  localparam logic [3:0] C_PUNCH_LAST = 4'(PUNCH_CYCLES - 1);
  localparam logic [3:0] C_KICK_RNG   = 4'(KICK_RANGE);
  localparam logic [3:0] C_PUNCH_RNG  = 4'(PUNCH_RANGE);

  state_t     state_q, state_d;
  logic [3:0] pos_q, pos_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] prev_action_q, prev_action_d;
  logic       hit_q, hit_d;
  logic [1:0] hit_dmg_q, hit_dmg_d;

  logic [2:0] w_act;
  logic [3:0] w_dist;
  logic       w_new_press;
  logic       w_can_move;

  always_comb begin
    w_act       = (bus.action == C_ACT_RSVD) ? C_ACT_NONE : bus.action;
    w_dist      = (bus.opp_pos > pos_q) ? (bus.opp_pos - pos_q) : 4'd0;
    w_new_press = (w_act != prev_action_q);
    w_can_move  = (state_q == ST_IDLE) || (state_q == ST_JUMP);

    state_d       = state_q;
    pos_d         = pos_q;
    cnt_d         = cnt_q;
    prev_action_d = w_act;
    hit_d         = 1'b0;
    hit_dmg_d     = 2'd0;

    // Forward stops one square short of the opponent; both directions saturate.
    if (w_can_move) begin
      if (w_act == C_ACT_FWD && pos_q < MAX_POS && w_dist > 4'd1) begin
        pos_d = pos_q + 4'd1;
      end else if (w_act == C_ACT_BACK && pos_q > 4'd0) begin
        pos_d = pos_q - 4'd1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (w_new_press && w_act == C_ACT_JUMP) begin
          state_d = ST_JUMP;
          cnt_d   = 4'd0;
        end else if (w_new_press && w_act == C_ACT_KICK) begin
          state_d = ST_KICK;
          cnt_d   = 4'd0;
        end else if (w_new_press && w_act == C_ACT_PUNCH) begin
          state_d = ST_PUNCH;
          cnt_d   = 4'd0;
        end else if (w_act == C_ACT_GUARD) begin
          state_d = ST_GUARD;
        end
      end
      ST_JUMP: begin
        if (cnt_q == C_JUMP_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_KICK: begin
        if (cnt_q == C_KICK_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
          if (w_dist <= C_KICK_RNG) begin
            hit_d     = 1'b1;
            hit_dmg_d = 2'd2;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_PUNCH: begin
        if (cnt_q == C_PUNCH_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
          if (w_dist <= C_PUNCH_RNG) begin
            hit_d     = 1'b1;
            hit_dmg_d = 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_GUARD: begin
        if (w_act != C_ACT_GUARD) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pos_q         <= START_POS;
      cnt_q         <= 4'd0;
      prev_action_q <= C_ACT_NONE;
      hit_q         <= 1'b0;
      hit_dmg_q     <= 2'd0;
    end else begin
      state_q       <= state_d;
      pos_q         <= pos_d;
      cnt_q         <= cnt_d;
      prev_action_q <= prev_action_d;
      hit_q         <= hit_d;
      hit_dmg_q     <= hit_dmg_d;
    end
  end

  assign bus.pos      = pos_q;
  assign bus.state    = state_q;
  assign bus.hit      = hit_q;
  assign bus.hit_dmg  = hit_dmg_q;
  assign bus.airborne = (state_q == ST_JUMP);
  assign bus.guarding = (state_q == ST_GUARD);
  assign bus.busy     = (state_q == ST_JUMP) || (state_q == ST_KICK) || (state_q == ST_PUNCH);

endmodule

`default_nettype wire

// File: doc/player_fsm.md
PLAYER_FSM -- requirements
Module: player_fsm

Interface
REQ-001 Parameters (name, default, meaning): START_POS, 4'd2, position after reset; MAX_POS, 4'd15, upper position limit; JUMP_CYCLES, 4, airborne duration; KICK_CYCLES, 3, kick duration; PUNCH_CYCLES, 2, punch duration; KICK_RANGE, 2, max kick distance; PUNCH_RANGE, 1, max punch distance.
REQ-002 Ports (name, direction, width, meaning): clk, input, 1, single clock, all logic on rising edge.
REQ-003 rst, input, 1, synchronous active-high reset.
REQ-004 action, input, 3, action code: 0 none, 1 jump, 2 kick, 3 punch, 4 guard, 5 move-forward, 6 move-back, 7 reserved.
REQ-005 opp_pos, input, 4, opponent position; the player faces increasing position.
REQ-006 pos, output, 4, registered player position.
REQ-007 state, output, 3, registered FSM state: 0 IDLE, 1 JUMP, 2 KICK, 3 PUNCH, 4 GUARD.
REQ-008 hit, output, 1, one-cycle registered pulse on a landed attack.
REQ-009 hit_dmg, output, 2, damage qualifying hit (kick 2, punch 1); 0 when hit=0.
REQ-010 airborne, guarding, busy, outputs, 1 each: state==JUMP; state==GUARD; state is JUMP, KICK or PUNCH.

Function
REQ-011 dist = opp_pos - pos when opp_pos > pos, else 0 (unsigned, 4 bits, no wrap).
REQ-012 Action code 7 SHALL be treated as 0 (none).
REQ-013 prev_action register holds the action sampled last cycle; jump/kick/punch are edge-accepted only when action != prev_action.
REQ-014 IDLE: accepted jump -> JUMP, kick -> KICK, punch -> PUNCH, counter cleared to 0; action==4 -> GUARD (level, no edge needed); otherwise stay IDLE.
REQ-015 Movement, in IDLE and JUMP only: action==5 increments pos by 1 per cycle only if pos < MAX_POS and dist > 1; action==6 decrements pos by 1 per cycle only if pos > 0; saturate, never wrap.
REQ-016 No movement in KICK, PUNCH or GUARD; held move codes are ignored there.
REQ-017 JUMP: counter increments each cycle; after JUMP_CYCLES cycles in JUMP -> IDLE; attack codes are ignored while airborne.
REQ-018 KICK: lasts KICK_CYCLES cycles; in the last cycle (counter==KICK_CYCLES-1), if dist <= KICK_RANGE, hit=1 and hit_dmg=2 on the following rising edge (registered); then -> IDLE.
REQ-019 PUNCH: same as REQ-018 with PUNCH_CYCLES, PUNCH_RANGE, hit_dmg=1.
REQ-020 GUARD: stay while action==4; any other code -> IDLE next edge, and that code is not acted on in the same cycle.
REQ-021 hit SHALL be high for exactly one cycle per attack, never two consecutive cycles.
REQ-022 An attack code still held when returning to IDLE SHALL NOT retrigger (prev_action equal); release then re-press is required.
REQ-023 opp_pos <= pos: dist=0, forward move blocked, attacks in range land.
REQ-024 Latency: action sampled at edge N -> state/pos change visible after edge N.

Reset
REQ-025 rst high at an edge: state=IDLE, pos=START_POS, counter=0, prev_action=0, hit=0, hit_dmg=0, airborne=0, guarding=0, busy=0.
REQ-026 rst SHALL override any in-progress jump or attack; an attack interrupted by reset produces no hit.
REQ-027 First cycle after reset release: a held attack code counts as an edge (prev_action=0).

Verification
REQ-028 Reset, opp_pos=8, action=5 held 10 cycles -> pos 2,3..7 then holds at 7 (dist=1).
REQ-029 pos=7, opp_pos=9, action=2 for 1 cycle then 0 -> state KICK 3 cycles, hit=1 hit_dmg=2 for one cycle, back to IDLE.
REQ-030 pos=5, opp_pos=9, action=3 pulse -> PUNCH 2 cycles, hit stays 0 (dist 4 > 1).
REQ-031 action=1 then action=6 held, pos=3 -> airborne 4 cycles, pos decrements each cycle to 0 and saturates; action=2 during jump ignored.
REQ-032 action=2 held 8 cycles -> exactly one kick and one hit pulse; action=4 held -> guarding=1, release -> IDLE next edge.
REQ-033 rst asserted in kick cycle 2 with dist=1 -> no hit, pos=2, state IDLE next cycle.
